// File: rtl/axi_reg_initiator_pkg.sv
// Shared types and AXI constants for the register-access AXI initiator.
//
// Contents:
//   state_t      - initiator FSM states
//   BURST_INCR   - AxBURST encoding for incrementing bursts
//   RESP_OKAY    - xRESP encoding for a normal completion
//   RESP_SLVERR  - xRESP encoding used when a response has to be rejected
//   axi_size()   - AxSIZE encoding for a full-width beat of a given data width
package axi_reg_initiator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRESP,
        ST_READ,
        ST_RRESP,
        ST_RESP
    } state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // AxSIZE is log2 of the number of bytes in one beat; every access is a
    // full-width beat, so the encoding follows from the bus width alone.
    function automatic logic [2:0] axi_size(input int unsigned data_width);
        logic [2:0] size;
        size = '0;
        for (int i = 0; i < 8; i++) begin
            if ((32'd8 << i) == data_width) begin
                size = 3'(i);
            end
        end
        return size;
    endfunction

endpackage

// File: rtl/axi_reg_initiator.sv
// Single-outstanding AXI4 master that turns one valid/ready register command
// into one single-beat AXI read or write and hands the result back on a
// valid/ready response channel.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   req_valid/req_ready    command handshake
//   req_we                 1 = write, 0 = read
//   req_addr               byte address
//   req_wdata, req_strb    write data and byte strobes
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata              read data (0 for writes)
//   rsp_resp               BRESP/RRESP, or SLVERR when the response is malformed
//   m_axi_aw*/w*/b*/ar*/r* flat AXI4 master channels
module axi_reg_initiator
    import axi_reg_initiator_pkg::*;
#(
    parameter int                      AXI_ID_WIDTH   = 10,
    parameter int                      AXI_ADDR_WIDTH = 64,
    parameter int                      AXI_DATA_WIDTH = 64,
    parameter int                      AXI_USER_WIDTH = 1,
    parameter logic [AXI_ID_WIDTH-1:0] TXN_ID         = '0
) (
    input  logic                        aclk,
    input  logic                        aresetn,

    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] req_strb,

    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                  rsp_resp,

    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic                        m_axi_awlock,
    output logic [3:0]                  m_axi_awcache,
    output logic [2:0]                  m_axi_awprot,
    output logic [3:0]                  m_axi_awqos,
    output logic [3:0]                  m_axi_awregion,
    output logic [AXI_USER_WIDTH-1:0]   m_axi_awuser,

    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic [AXI_USER_WIDTH-1:0]   m_axi_wuser,

    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                  m_axi_bresp,
    input  logic [AXI_USER_WIDTH-1:0]   m_axi_buser,

    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,
    output logic                        m_axi_arlock,
    output logic [3:0]                  m_axi_arcache,
    output logic [2:0]                  m_axi_arprot,
    output logic [3:0]                  m_axi_arqos,
    output logic [3:0]                  m_axi_arregion,
    output logic [AXI_USER_WIDTH-1:0]   m_axi_aruser,

    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rlast,
    input  logic [AXI_USER_WIDTH-1:0]   m_axi_ruser
);

    localparam logic [2:0] BEAT_SIZE = axi_size(AXI_DATA_WIDTH);

    state_t                        state;
    state_t                        state_next;
    logic                          aw_done;
    logic                          w_done;
    logic [AXI_ADDR_WIDTH-1:0]     addr_q;
    logic [AXI_DATA_WIDTH-1:0]     wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0]   strb_q;

    // User sideband on the response channels carries nothing we act on.
    logic unused_inputs;
    assign unused_inputs = ^{m_axi_buser, m_axi_ruser};

    // Every access is one full-width INCR beat with a fixed ID and no
    // special attributes, so the request-side sideband is constant.
    assign m_axi_awid     = TXN_ID;
    assign m_axi_awaddr   = addr_q;
    assign m_axi_awlen    = 8'd0;
    assign m_axi_awsize   = BEAT_SIZE;
    assign m_axi_awburst  = BURST_INCR;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awcache  = 4'd0;
    assign m_axi_awprot   = 3'd0;
    assign m_axi_awqos    = 4'd0;
    assign m_axi_awregion = 4'd0;
    assign m_axi_awuser   = '0;

    assign m_axi_wdata    = wdata_q;
    assign m_axi_wstrb    = strb_q;
    assign m_axi_wlast    = 1'b1;
    assign m_axi_wuser    = '0;

    assign m_axi_arid     = TXN_ID;
    assign m_axi_araddr   = addr_q;
    assign m_axi_arlen    = 8'd0;
    assign m_axi_arsize   = BEAT_SIZE;
    assign m_axi_arburst  = BURST_INCR;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arcache  = 4'd0;
    assign m_axi_arprot   = 3'd0;
    assign m_axi_arqos    = 4'd0;
    assign m_axi_arregion = 4'd0;
    assign m_axi_aruser   = '0;

    // State register. Reset abandons whatever transaction was in flight;
    // the slave shares this reset, so nothing is left half-finished there.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and all handshake outputs. Outputs are pure functions of
    // the state and done flags, so reset forces them inactive immediately.
    // In WRITE, a channel whose done flag is clear is still presenting
    // valid, so its ready alone means its handshake completes this cycle.
    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        rsp_valid     = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_we ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                m_axi_awvalid = !aw_done;
                m_axi_wvalid  = !w_done;
                if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) begin
                    state_next = ST_WRESP;
                end
            end
            ST_WRESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    state_next = ST_RESP;
                end
            end
            ST_READ: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_next = ST_RRESP;
                end
            end
            ST_RRESP: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // AW and W complete independently; each flag remembers that its channel
    // has already handshaken so its valid drops while the other still waits.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == ST_IDLE) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == ST_WRITE) begin
            if (m_axi_awvalid && m_axi_awready) begin
                aw_done <= 1'b1;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_done <= 1'b1;
            end
        end
    end

    // Command capture so the AXI channels stay stable while the slave stalls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (state == ST_IDLE && req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            strb_q  <= req_strb;
        end
    end

    // Response capture. A beat carrying a foreign ID, or a read beat that is
    // not marked last, cannot belong to our single-beat request, so it is
    // reported as SLVERR rather than trusted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
        end else if (state == ST_WRESP && m_axi_bvalid) begin
            rsp_rdata <= '0;
            rsp_resp  <= (m_axi_bid != TXN_ID) ? RESP_SLVERR : m_axi_bresp;
        end else if (state == ST_RRESP && m_axi_rvalid) begin
            rsp_rdata <= m_axi_rdata;
            rsp_resp  <= ((m_axi_rid != TXN_ID) || !m_axi_rlast) ? RESP_SLVERR : m_axi_rresp;
        end
    end

endmodule

// File: tb/tb_axi_reg_initiator.sv
// Self-checking bench for axi_reg_initiator: a configurable AXI slave with
// per-channel ready/response delays, directed scenarios and a randomized
// transaction loop, each response compared against expectations derived
// from the command and the slave's configured reply.
module tb_axi_reg_initiator;

    localparam int         IDW = 10;
    localparam int         AW  = 64;
    localparam int         DW  = 64;
    localparam int         SW  = DW / 8;
    localparam logic [9:0] TXN = 10'h015;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_strb;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;

    logic m_axi_awvalid, m_axi_awready, m_axi_awlock;
    logic [IDW-1:0] m_axi_awid;
    logic [AW-1:0]  m_axi_awaddr;
    logic [7:0]     m_axi_awlen;
    logic [2:0]     m_axi_awsize, m_axi_awprot;
    logic [1:0]     m_axi_awburst;
    logic [3:0]     m_axi_awcache, m_axi_awqos, m_axi_awregion;
    logic [0:0]     m_axi_awuser;
    logic           m_axi_wvalid, m_axi_wready, m_axi_wlast;
    logic [DW-1:0]  m_axi_wdata;
    logic [SW-1:0]  m_axi_wstrb;
    logic [0:0]     m_axi_wuser;
    logic           m_axi_bvalid, m_axi_bready;
    logic [IDW-1:0] m_axi_bid;
    logic [1:0]     m_axi_bresp;
    logic [0:0]     m_axi_buser;
    logic m_axi_arvalid, m_axi_arready, m_axi_arlock;
    logic [IDW-1:0] m_axi_arid;
    logic [AW-1:0]  m_axi_araddr;
    logic [7:0]     m_axi_arlen;
    logic [2:0]     m_axi_arsize, m_axi_arprot;
    logic [1:0]     m_axi_arburst;
    logic [3:0]     m_axi_arcache, m_axi_arqos, m_axi_arregion;
    logic [0:0]     m_axi_aruser;
    logic           m_axi_rvalid, m_axi_rready, m_axi_rlast;
    logic [IDW-1:0] m_axi_rid;
    logic [DW-1:0]  m_axi_rdata;
    logic [1:0]     m_axi_rresp;
    logic [0:0]     m_axi_ruser;

    axi_reg_initiator #(
        .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
        .AXI_USER_WIDTH(1), .TXN_ID(TXN)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awqos(m_axi_awqos), .m_axi_awregion(m_axi_awregion),
        .m_axi_awuser(m_axi_awuser),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wuser(m_axi_wuser),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_buser(m_axi_buser),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arqos(m_axi_arqos), .m_axi_arregion(m_axi_arregion),
        .m_axi_aruser(m_axi_aruser),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_ruser(m_axi_ruser)
    );

    int check_count = 0;
    int error_count = 0;

    // Slave configuration for the next transaction.
    int          cfg_aw_dly, cfg_w_dly, cfg_b_dly, cfg_ar_dly, cfg_r_dly;
    logic [1:0]  cfg_resp;
    bit          cfg_id_err, cfg_rlast_err;
    logic [63:0] cfg_rdata;

    // What the slave observed.
    int          n_aw, n_w, n_b, n_ar, n_r, const_bad, proto_bad;
    logic [63:0] seen_addr, seen_wdata;
    logic [7:0]  seen_strb;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // AXI slave: channel events are sampled at the falling edge, responses
    // and readies are updated just after the rising edge.
    initial begin : slave
        bit aw_seen, w_seen, ar_seen, aw_hs, w_hs, ar_hs, b_hs, r_hs;
        bit aw_pend, w_pend, ar_pend;
        logic [63:0] aw_pend_addr, w_pend_data, ar_pend_addr;
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        aw_seen = 0; w_seen = 0; ar_seen = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0;
        aw_pend_addr = '0; w_pend_data = '0; ar_pend_addr = '0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_bid = '0; m_axi_bresp = '0; m_axi_buser = '0;
        m_axi_rvalid = 0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
        m_axi_rlast = 0; m_axi_ruser = '0;
        forever begin
            @(negedge aclk);
            aw_hs = m_axi_awvalid && m_axi_awready;
            w_hs  = m_axi_wvalid && m_axi_wready;
            ar_hs = m_axi_arvalid && m_axi_arready;
            b_hs  = m_axi_bvalid && m_axi_bready;
            r_hs  = m_axi_rvalid && m_axi_rready;
            if (aw_pend && (!m_axi_awvalid || m_axi_awaddr != aw_pend_addr)) proto_bad++;
            if (w_pend && (!m_axi_wvalid || m_axi_wdata != w_pend_data)) proto_bad++;
            if (ar_pend && (!m_axi_arvalid || m_axi_araddr != ar_pend_addr)) proto_bad++;
            aw_pend = m_axi_awvalid && !m_axi_awready; aw_pend_addr = m_axi_awaddr;
            w_pend  = m_axi_wvalid && !m_axi_wready;   w_pend_data  = m_axi_wdata;
            ar_pend = m_axi_arvalid && !m_axi_arready; ar_pend_addr = m_axi_araddr;
            if ((m_axi_awvalid && aw_seen) || (m_axi_wvalid && w_seen) || (m_axi_arvalid && ar_seen)) proto_bad++;
            if (aw_hs) begin
                n_aw++;
                seen_addr = m_axi_awaddr;
                if (m_axi_awlen != 0 || m_axi_awsize != 3 || m_axi_awburst != 2'b01 || m_axi_awlock ||
                    m_axi_awcache != 0 || m_axi_awprot != 0 || m_axi_awqos != 0 || m_axi_awregion != 0 ||
                    m_axi_awuser != 0 || m_axi_awid != TXN) const_bad++;
            end
            if (w_hs) begin
                n_w++;
                seen_wdata = m_axi_wdata;
                seen_strb  = m_axi_wstrb;
                if (!m_axi_wlast || m_axi_wuser != 0) const_bad++;
            end
            if (ar_hs) begin
                n_ar++;
                seen_addr = m_axi_araddr;
                if (m_axi_arlen != 0 || m_axi_arsize != 3 || m_axi_arburst != 2'b01 || m_axi_arlock ||
                    m_axi_arcache != 0 || m_axi_arprot != 0 || m_axi_arqos != 0 || m_axi_arregion != 0 ||
                    m_axi_aruser != 0 || m_axi_arid != TXN) const_bad++;
            end
            if (b_hs) n_b++;
            if (r_hs) n_r++;
            if (m_axi_awvalid && !m_axi_awready) aw_cnt++;
            if (m_axi_wvalid && !m_axi_wready) w_cnt++;
            if (m_axi_arvalid && !m_axi_arready) ar_cnt++;
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                aw_seen = 0; w_seen = 0; ar_seen = 0;
                aw_pend = 0; w_pend = 0; ar_pend = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
                m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
            end else begin
                if (aw_hs) aw_seen = 1;
                if (w_hs) w_seen = 1;
                if (ar_hs) ar_seen = 1;
                if (b_hs) begin
                    m_axi_bvalid = 0; aw_seen = 0; w_seen = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                end
                if (r_hs) begin
                    m_axi_rvalid = 0; m_axi_rlast = 0; ar_seen = 0; ar_cnt = 0; r_cnt = 0;
                end
                m_axi_awready = !aw_seen && (aw_cnt >= cfg_aw_dly);
                m_axi_wready  = !w_seen && (w_cnt >= cfg_w_dly);
                m_axi_arready = !ar_seen && (ar_cnt >= cfg_ar_dly);
                if (aw_seen && w_seen && !m_axi_bvalid) begin
                    if (b_cnt >= cfg_b_dly) begin
                        m_axi_bvalid = 1;
                        m_axi_bid    = cfg_id_err ? TXN + 10'd1 : TXN;
                        m_axi_bresp  = cfg_resp;
                    end else begin
                        b_cnt++;
                    end
                end
                if (ar_seen && !m_axi_rvalid) begin
                    if (r_cnt >= cfg_r_dly) begin
                        m_axi_rvalid = 1;
                        m_axi_rid    = cfg_id_err ? TXN + 10'd1 : TXN;
                        m_axi_rresp  = cfg_resp;
                        m_axi_rdata  = cfg_rdata;
                        m_axi_rlast  = !cfg_rlast_err;
                    end else begin
                        r_cnt++;
                    end
                end
            end
        end
    end

    task automatic clearObservations();
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; const_bad = 0; proto_bad = 0;
        seen_addr = '0; seen_wdata = '0; seen_strb = '0;
    endtask

    task automatic setSlave(input int awd, input int wd, input int bd, input int ard, input int rd,
                            input logic [1:0] resp, input bit id_err, input bit rlast_err,
                            input logic [63:0] rdata);
        cfg_aw_dly = awd; cfg_w_dly = wd; cfg_b_dly = bd; cfg_ar_dly = ard; cfg_r_dly = rd;
        cfg_resp = resp; cfg_id_err = id_err; cfg_rlast_err = rlast_err; cfg_rdata = rdata;
    endtask

    // Starts and ends just after a rising edge.
    task automatic sendRequest(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [7:0] strb, output bit ok, output int waited);
        req_we = we; req_addr = addr; req_wdata = wdata; req_strb = strb; req_valid = 1;
        waited = 0;
        @(negedge aclk);
        while (!req_ready && waited < 50) begin
            waited++;
            @(negedge aclk);
        end
        ok = req_ready;
        @(posedge aclk);
        #1;
        req_valid = 0;
    endtask

    // Waits for the response, optionally stalls it for 'hold' cycles while
    // checking it stays put, and optionally presents the next command early.
    task automatic collectResponse(input int hold, input bit preload, output logic [63:0] got_rdata,
                                   output logic [1:0] got_resp, output int lat, output bit ok);
        int stable_bad, blocked_bad;
        rsp_ready = (hold == 0);
        lat = 1;
        @(negedge aclk);
        while (!rsp_valid && lat < 60) begin
            lat++;
            @(negedge aclk);
        end
        ok = rsp_valid;
        got_rdata = rsp_rdata;
        got_resp = rsp_resp;
        if (hold > 0) begin
            stable_bad = 0;
            blocked_bad = 0;
            for (int i = 0; i < hold; i++) begin
                @(posedge aclk);
                #1;
                if (preload) req_valid = 1;
                @(negedge aclk);
                if (!rsp_valid || rsp_rdata !== got_rdata || rsp_resp !== got_resp) stable_bad++;
                if (preload && req_ready) blocked_bad++;
            end
            checkOutput("rsp_stable", stable_bad, 0);
            if (preload) checkOutput("req_blocked", blocked_bad, 0);
            @(posedge aclk);
            #1;
            rsp_ready = 1;
            @(negedge aclk);
        end
        @(posedge aclk);
        #1;
        rsp_ready = 0;
    endtask

    task automatic applyStimulus(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [7:0] strb, input int awd, input int wd, input int bd,
                                 input int ard, input int rd, input logic [1:0] resp, input bit id_err,
                                 input bit rlast_err, input logic [63:0] rdata, input int hold);
        bit ok;
        int waited, lat;
        logic [63:0] got_rdata, exp_rdata;
        logic [1:0]  got_resp, exp_resp;
        setSlave(awd, wd, bd, ard, rd, resp, id_err, rlast_err, rdata);
        clearObservations();
        sendRequest(we, addr, wdata, strb, ok, waited);
        checkOutput("req_accept", ok, 1);
        collectResponse(hold, 0, got_rdata, got_resp, lat, ok);
        checkOutput("rsp_arrived", ok, 1);
        exp_rdata = we ? 64'd0 : rdata;
        exp_resp  = (id_err || (!we && rlast_err)) ? 2'b10 : resp;
        checkOutput("rsp_rdata", got_rdata, exp_rdata);
        checkOutput("rsp_resp", got_resp, exp_resp);
        checkOutput("aw_count", n_aw, we);
        checkOutput("w_count", n_w, we);
        checkOutput("b_count", n_b, we);
        checkOutput("ar_count", n_ar, !we);
        checkOutput("r_count", n_r, !we);
        checkOutput("axi_addr", seen_addr, addr);
        if (we) begin
            checkOutput("axi_wdata", seen_wdata, wdata);
            checkOutput("axi_wstrb", seen_strb, strb);
        end
        checkOutput("const_fields", const_bad, 0);
        checkOutput("valid_rules", proto_bad, 0);
        if (awd == 0 && wd == 0 && bd == 0 && ard == 0 && rd == 0)
            checkOutput("latency", lat, 3);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin : main
        bit ok;
        int waited, lat, cnt;
        logic [63:0] got_rdata;
        logic [1:0]  got_resp;
        req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_strb = '0; rsp_ready = 0;
        setSlave(0, 0, 0, 0, 0, 2'b00, 0, 0, 64'd0);
        clearObservations();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checkOutput("reset_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                   m_axi_rready, rsp_valid, req_ready}, 7'b0000001);
        checkOutput("reset_rdata", rsp_rdata, 0);
        checkOutput("reset_resp", rsp_resp, 0);
        aresetn = 1;
        @(posedge aclk);
        #1;

        $display("[TB] directed zero-wait write");
        applyStimulus(1, 64'h0C00_2000, 64'h1, 8'hFF, 0, 0, 0, 0, 0, 2'b00, 0, 0, 64'd0, 0);
        $display("[TB] directed read with AR stall");
        applyStimulus(0, 64'h0200_BFF8, 64'h0, 8'h00, 0, 0, 0, 5, 0, 2'b00, 0, 0, 64'hDEAD_BEEF, 0);
        $display("[TB] directed write with late W ready");
        applyStimulus(1, 64'h0C00_2004, 64'hA5A5_0000_1234_5678, 8'h0F, 0, 3, 0, 0, 0, 2'b00, 0, 0, 64'd0, 0);
        $display("[TB] directed read error responses");
        applyStimulus(0, 64'h0200_4000, 64'h0, 8'h00, 0, 0, 0, 0, 0, 2'b00, 1, 0, 64'h1111, 0);
        applyStimulus(0, 64'h0200_4008, 64'h0, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 1, 64'h2222, 0);
        applyStimulus(0, 64'h0200_4010, 64'h0, 8'h00, 0, 0, 0, 0, 0, 2'b11, 0, 0, 64'hCAFE_F00D, 0);

        $display("[TB] reset during write response wait");
        setSlave(0, 0, 6, 0, 0, 2'b00, 0, 0, 64'd0);
        clearObservations();
        sendRequest(1, 64'h0C00_3000, 64'h77, 8'hFF, ok, waited);
        checkOutput("rst_req_accept", ok, 1);
        cnt = 0;
        @(negedge aclk);
        while (!m_axi_bready && cnt < 20) begin
            cnt++;
            @(negedge aclk);
        end
        checkOutput("rst_in_wresp", m_axi_bready, 1);
        #2;
        aresetn = 0;
        #1;
        checkOutput("rst_async_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                       m_axi_rready, rsp_valid, req_ready}, 7'b0000001);
        checkOutput("rst_async_rdata", rsp_rdata, 0);
        checkOutput("rst_async_resp", rsp_resp, 0);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        #2;
        aresetn = 1;
        @(posedge aclk);
        #1;
        applyStimulus(0, 64'h0200_BFF8, 64'h0, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 64'h0BAD_C0DE_0000_0001, 0);

        $display("[TB] stalled response with a queued command");
        setSlave(0, 0, 0, 0, 0, 2'b00, 0, 0, 64'h1234_5678_9ABC_DEF0);
        clearObservations();
        sendRequest(0, 64'h0C00_1000, 64'h0, 8'h00, ok, waited);
        checkOutput("ovl_req1_accept", ok, 1);
        req_we = 1; req_addr = 64'h0C00_1008; req_wdata = 64'h55; req_strb = 8'h01;
        collectResponse(10, 1, got_rdata, got_resp, lat, ok);
        checkOutput("ovl_rsp1_arrived", ok, 1);
        checkOutput("ovl_rsp1_rdata", got_rdata, 64'h1234_5678_9ABC_DEF0);
        checkOutput("ovl_rsp1_resp", got_resp, 2'b00);
        clearObservations();
        sendRequest(1, 64'h0C00_1008, 64'h55, 8'h01, ok, waited);
        checkOutput("ovl_req2_next_cycle", waited, 0);
        collectResponse(0, 0, got_rdata, got_resp, lat, ok);
        checkOutput("ovl_rsp2_rdata", got_rdata, 0);
        checkOutput("ovl_rsp2_resp", got_resp, 2'b00);
        checkOutput("ovl_rsp2_b_count", n_b, 1);
        checkOutput("ovl_rsp2_wdata", seen_wdata, 64'h55);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 40; t++) begin
            applyStimulus($urandom_range(0, 1) == 1, {$urandom, $urandom}, {$urandom, $urandom},
                          8'($urandom_range(0, 255)), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                          2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
                          $urandom_range(0, 7) == 0, {$urandom, $urandom}, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
